// File: rtl/yadan_test_monitor_pkg.sv
// Shared definitions for the yadan self-test monitor: channel state encoding,
// default result code and a terminal-state helper.
package yadan_test_monitor_pkg;

    localparam int STATE_W = 3;
    localparam logic [31:0] MON_DEFAULT_CODE = 32'h1;

    typedef enum logic [STATE_W-1:0] {
        MON_IDLE   = 3'd0,
        MON_RUN    = 3'd1,
        MON_SETTLE = 3'd2,
        MON_PASS   = 3'd3,
        MON_FAIL   = 3'd4,
        MON_TMO    = 3'd5
    } mon_state_e;

    function automatic logic is_final(input mon_state_e s);
        return (s == MON_PASS) || (s == MON_FAIL) || (s == MON_TMO);
    endfunction

endpackage

// File: rtl/yadan_test_monitor_ch.sv
// One monitored channel: waits for the done code, lets the core settle, then
// latches a pass/fail verdict (and the failing test number).
module yadan_test_monitor_ch
    import yadan_test_monitor_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] DONE_CODE     = XLEN'(MON_DEFAULT_CODE),
    parameter logic [XLEN-1:0] PASS_CODE     = XLEN'(MON_DEFAULT_CODE),
    parameter int              SETTLE_CYCLES = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  logic            tmo_fire,
    input  logic [XLEN-1:0] done_val,
    input  logic [XLEN-1:0] pass_val,
    input  logic [XLEN-1:0] test_id,
    output mon_state_e      state,
    output logic [XLEN-1:0] fail_id
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    mon_state_e      state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] id_q, id_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MON_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        if (clear) begin
            state_d = MON_IDLE;
            cnt_d   = '0;
            id_d    = '0;
        end else if (en) begin
            // The watchdog wins over a done detect or settle expiry on the same edge.
            if (tmo_fire && !is_final(state_q)) begin
                state_d = MON_TMO;
            end else begin
                case (state_q)
                    MON_IDLE: state_d = MON_RUN;
                    MON_RUN: begin
                        if (done_val == DONE_CODE) begin
                            state_d = MON_SETTLE;
                            cnt_d   = SW'(SETTLE_CYCLES - 1);
                        end
                    end
                    MON_SETTLE: begin
                        if (cnt_q == '0) begin
                            if (pass_val == PASS_CODE) begin
                                state_d = MON_PASS;
                            end else begin
                                state_d = MON_FAIL;
                                id_d    = test_id;
                            end
                        end else begin
                            cnt_d = cnt_q - SW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state   = state_q;
    assign fail_id = id_q;

endmodule

// File: rtl/yadan_test_monitor.sv
// Multi-channel self-test result monitor: per-channel verdict FSMs, a global
// watchdog counter, and the summary/fail-channel decode for the bench and LEDs.
module yadan_test_monitor
    import yadan_test_monitor_pkg::*;
#(
    parameter int              NUM_CH         = 1,
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] DONE_CODE      = XLEN'(MON_DEFAULT_CODE),
    parameter logic [XLEN-1:0] PASS_CODE      = XLEN'(MON_DEFAULT_CODE),
    parameter int              SETTLE_CYCLES  = 5,
    parameter int              TIMEOUT_CYCLES = 50000,
    parameter int              CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clear_i,
    input  logic [NUM_CH*XLEN-1:0]    done_val_i,
    input  logic [NUM_CH*XLEN-1:0]    pass_val_i,
    input  logic [NUM_CH*XLEN-1:0]    test_id_i,
    output logic                      all_done_o,
    output logic                      pass_o,
    output logic                      fail_o,
    output logic                      timeout_o,
    output logic [NUM_CH-1:0]         fail_mask_o,
    output logic [2:0]                fail_ch_o,
    output logic [XLEN-1:0]           fail_id_o,
    output logic [CNT_W-1:0]          cycle_cnt_o,
    output logic [NUM_CH*STATE_W-1:0] ch_state_o
);

    mon_state_e      ch_state [NUM_CH];
    logic [XLEN-1:0] ch_id    [NUM_CH];

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             all_done;
    logic             all_pass;
    logic             any_fail;
    logic             found;
    logic             tmo_fire;

    assign tmo_fire = en_i && !clear_i && !all_done && !timeout_q &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (en_i && !all_done && !timeout_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (tmo_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        yadan_test_monitor_ch #(
            .XLEN          (XLEN),
            .DONE_CODE     (DONE_CODE),
            .PASS_CODE     (PASS_CODE),
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en_i),
            .clear    (clear_i),
            .tmo_fire (tmo_fire),
            .done_val (done_val_i[k*XLEN +: XLEN]),
            .pass_val (pass_val_i[k*XLEN +: XLEN]),
            .test_id  (test_id_i[k*XLEN +: XLEN]),
            .state    (ch_state[k]),
            .fail_id  (ch_id[k])
        );
    end

    // Reduction plus lowest-index priority encode of failing channels.
    always_comb begin
        all_done    = 1'b1;
        all_pass    = 1'b1;
        any_fail    = 1'b0;
        found       = 1'b0;
        fail_mask_o = '0;
        fail_ch_o   = '0;
        fail_id_o   = '0;
        ch_state_o  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_state_o[k*STATE_W +: STATE_W] = ch_state[k];
            if (!is_final(ch_state[k])) all_done = 1'b0;
            if (ch_state[k] != MON_PASS) all_pass = 1'b0;
            if (ch_state[k] == MON_FAIL) begin
                fail_mask_o[k] = 1'b1;
                any_fail       = 1'b1;
                if (!found) begin
                    found     = 1'b1;
                    fail_ch_o = 3'(k);
                    fail_id_o = ch_id[k];
                end
            end
        end
    end

    assign all_done_o  = all_done;
    assign pass_o      = all_done && all_pass;
    assign fail_o      = any_fail;
    assign timeout_o   = timeout_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_yadan_test_monitor.sv
// Directed bench for yadan_test_monitor: a cycle-level verdict model checked
// against the DUT every cycle, plus hand-computed checkpoints.
module tb_yadan_test_monitor;
    import yadan_test_monitor_pkg::*;

    localparam int NCH    = 4;
    localparam int XL     = 32;
    localparam int SETTLE = 5;
    localparam int TMO    = 200;
    localparam int CW     = 16;
    localparam logic [XL-1:0] DONE_C = 32'h1;
    localparam logic [XL-1:0] PASS_C = 32'h1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   clear;
    logic [NCH*XL-1:0]      done_v;
    logic [NCH*XL-1:0]      pass_v;
    logic [NCH*XL-1:0]      tid_v;
    logic                   all_done, pass, fail, timeout;
    logic [NCH-1:0]         fail_mask;
    logic [2:0]             fail_ch;
    logic [XL-1:0]          fail_id;
    logic [CW-1:0]          cycle_cnt;
    logic [NCH*STATE_W-1:0] ch_state;

    int n_checks = 0;
    int n_errors = 0;

    yadan_test_monitor #(
        .NUM_CH(NCH), .XLEN(XL), .DONE_CODE(DONE_C), .PASS_CODE(PASS_C),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .en_i(en), .clear_i(clear),
        .done_val_i(done_v), .pass_val_i(pass_v), .test_id_i(tid_v),
        .all_done_o(all_done), .pass_o(pass), .fail_o(fail), .timeout_o(timeout),
        .fail_mask_o(fail_mask), .fail_ch_o(fail_ch), .fail_id_o(fail_id),
        .cycle_cnt_o(cycle_cnt), .ch_state_o(ch_state)
    );

    always #5 clk = ~clk;

    // Model: verdict per channel (0 none, 1 pass, 2 fail, 3 timeout), edges
    // left until sampling, and the enabled-cycle count.
    int          m_cnt = 0;
    bit          m_tmo = 0;
    bit          m_started [NCH];
    int          m_left    [NCH];
    int          m_verdict [NCH];
    logic [31:0] m_id      [NCH];

    task automatic model_reset();
        m_cnt = 0;
        m_tmo = 0;
        for (int k = 0; k < NCH; k++) begin
            m_started[k] = 0; m_left[k] = 0; m_verdict[k] = 0; m_id[k] = '0;
        end
    endtask

    function automatic bit m_all_done();
        for (int k = 0; k < NCH; k++) if (m_verdict[k] == 0) return 0;
        return 1;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || clear) begin
                model_reset();
            end else if (en) begin
                bit all_d, fire;
                all_d = m_all_done();
                fire  = !all_d && !m_tmo && (m_cnt == TMO - 1);
                if (!all_d && !m_tmo) m_cnt++;
                if (fire) m_tmo = 1;
                for (int k = 0; k < NCH; k++) begin
                    if (m_verdict[k] != 0) continue;
                    if (fire) m_verdict[k] = 3;
                    else if (!m_started[k]) m_started[k] = 1;
                    else if (m_left[k] > 0) begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            if (pass_v[k*XL +: XL] == PASS_C) m_verdict[k] = 1;
                            else begin
                                m_verdict[k] = 2;
                                m_id[k] = tid_v[k*XL +: XL];
                            end
                        end
                    end else if (done_v[k*XL +: XL] == DONE_C) m_left[k] = SETTLE;
                end
            end
        end
    end

    function automatic logic [2:0] exp_state(int k);
        case (m_verdict[k])
            1: return MON_PASS;
            2: return MON_FAIL;
            3: return MON_TMO;
            default: ;
        endcase
        if (m_left[k] > 0) return MON_SETTLE;
        if (m_started[k]) return MON_RUN;
        return MON_IDLE;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] e_mask;
        logic [2:0]     e_ch;
        logic [31:0]    e_id;
        bit             e_all, e_pass, found;
        e_mask = '0; e_ch = '0; e_id = '0; found = 0;
        e_all  = m_all_done();
        e_pass = e_all;
        for (int k = 0; k < NCH; k++) begin
            if (m_verdict[k] != 1) e_pass = 0;
            if (m_verdict[k] == 2) begin
                e_mask[k] = 1'b1;
                if (!found) begin
                    found = 1; e_ch = 3'(k); e_id = m_id[k];
                end
            end
        end
        check("all_done", all_done, e_all);
        check("pass", pass, e_pass);
        check("fail", fail, |e_mask);
        check("timeout", timeout, m_tmo);
        check("fail_mask", fail_mask, e_mask);
        check("fail_ch", fail_ch, e_ch);
        check("fail_id", fail_id, e_id);
        check("cycle_cnt", cycle_cnt, m_cnt);
        for (int k = 0; k < NCH; k++)
            check($sformatf("ch%0d_state", k), ch_state[k*STATE_W +: STATE_W], exp_state(k));
    endtask

    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic [31:0] d, input logic [31:0] p, input logic [31:0] t);
        done_v[k*XL +: XL] = d;
        pass_v[k*XL +: XL] = p;
        tid_v[k*XL +: XL]  = t;
    endtask

    task automatic do_clear();
        done_v = '0; pass_v = '0; tid_v = '0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_cnt", cycle_cnt, 0);
        check("clear_done", all_done, 0);
        check("clear_pass", pass, 0);
        check("clear_fail", fail, 0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0;
        done_v = '0; pass_v = '0; tid_v = '0;
        tick(3);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_state", ch_state, 0);
        check("rst_timeout", timeout, 0);

        // All channels done at cycle 100 with pass.
        rst = 1'b1; en = 1'b1;
        tick(99);
        for (int k = 0; k < NCH; k++) set_ch(k, 1, 1, 0);
        tick(5);
        check("t1_early_pass", pass, 0);
        check("t1_cnt104", cycle_cnt, 104);
        tick(1);
        check("t1_pass", pass, 1);
        check("t1_cnt105", cycle_cnt, 105);
        tick(10);
        check("t1_frozen", cycle_cnt, 105);

        // ch0 fails with id 17, the rest pass.
        do_clear();
        tick(10);
        set_ch(0, 1, 0, 17);
        for (int k = 1; k < NCH; k++) set_ch(k, 1, 1, 0);
        tick(6);
        check("t2_fail", fail, 1);
        check("t2_mask", fail_mask, 4'b0001);
        check("t2_id", fail_id, 17);
        check("t2_pass", pass, 0);

        // ch2 id 5 and ch3 id 9 fail at different times; ch0/ch1 pass.
        do_clear();
        tick(5);
        set_ch(0, 1, 1, 0);
        tick(3);
        set_ch(2, 1, 0, 5);
        tick(2);
        set_ch(3, 1, 0, 9);
        set_ch(1, 1, 1, 0);
        tick(10);
        check("t3_mask", fail_mask, 4'b1100);
        check("t3_ch", fail_ch, 2);
        check("t3_id", fail_id, 5);
        check("t3_done", all_done, 1);

        // Watchdog: only ch0 ever finishes.
        do_clear();
        set_ch(0, 1, 1, 0);
        tick(199);
        check("t4_pre_tmo", timeout, 0);
        tick(1);
        check("t4_tmo", timeout, 1);
        check("t4_cnt", cycle_cnt, 200);
        check("t4_ch1", ch_state[5:3], MON_TMO);
        check("t4_ch0", ch_state[2:0], MON_PASS);
        check("t4_pass", pass, 0);
        check("t4_done", all_done, 1);
        tick(5);
        check("t4_frozen", cycle_cnt, 200);

        // Done on the timeout edge and a channel still settling both go to TMO.
        do_clear();
        set_ch(0, 1, 1, 0);
        tick(196);
        set_ch(2, 1, 1, 0);
        tick(3);
        set_ch(1, 1, 1, 0);
        set_ch(3, 1, 1, 0);
        tick(1);
        check("t4b_ch1", ch_state[5:3], MON_TMO);
        check("t4b_ch2", ch_state[8:6], MON_TMO);
        check("t4b_ch3", ch_state[11:9], MON_TMO);

        // done toggles back to 0 during settle.
        do_clear();
        tick(3);
        for (int k = 0; k < NCH - 1; k++) set_ch(k, 1, 1, 0);
        set_ch(3, 1, 0, 3);
        tick(2);
        done_v = '0;
        tick(6);
        check("t5_done", all_done, 1);
        check("t5_id", fail_id, 3);

        // Asynchronous reset mid-settle, then a fresh run.
        do_clear();
        tick(3);
        for (int k = 0; k < NCH; k++) set_ch(k, 1, 1, 0);
        tick(2);
        #3 rst = 1'b0;
        #1;
        check("t5_rst_state", ch_state, 0);
        check("t5_rst_cnt", cycle_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(7);
        check("t5_rerun_pass", pass, 1);

        // en low mid-run holds the counter; clear then judge a second test.
        do_clear();
        tick(20);
        en = 1'b0;
        tick(50);
        check("t6_hold", cycle_cnt, 20);
        en = 1'b1;
        for (int k = 0; k < NCH; k++) set_ch(k, 1, 1, 0);
        tick(7);
        check("t6_pass", pass, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t6_clr_pass", pass, 0);
        check("t6_clr_cnt", cycle_cnt, 0);
        set_ch(3, 1, 0, 32'h55);
        tick(8);
        check("t6_fail_ch", fail_ch, 3);
        check("t6_fail_id", fail_id, 32'h55);
        check("t6_mask", fail_mask, 4'b1000);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
